// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader_pkg
// Description : Shared definitions for the instruction loader: FSM state
//               encoding, byte/word geometry constants and the word-index to
//               byte-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_loader_pkg;

    // Loader FSM state encoding (explicit 2-bit width).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A MIPS instruction word is four bytes; word index -> byte offset is <<2.
    localparam int BYTES_PER_WORD   = 4;
    localparam int WORD_BYTES_SHIFT = 2;

    // Byte address of word 'idx' relative to 'base'. The index is widened to
    // 32 bits before shifting so the offset is never truncated.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        return base + ({16'd0, idx} << WORD_BYTES_SHIFT);
    endfunction

endpackage : instruction_loader_pkg
`default_nettype wire

// File: rtl/instruction_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Big-endian byte-to-word packer. A 32-bit shift register takes
//               one byte per accepted beat (first byte ends up in 31:24); a
//               2-bit counter tracks the position within the word.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               clear          - drop any partial word, counter back to 0
//               byte_en        - a byte is accepted this cycle
//               byte_in[7:0]   - accepted byte
//               word_next[31:0]- assembled word including this cycle's byte
//               word_full      - this cycle's byte completes a word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q,   cnt_d;

    // word_next is combinational so the owner can capture a complete word on
    // the same edge that accepts its last byte (one-cycle write latency).
    assign word_next = byte_en ? {shift_q[23:0], byte_in} : shift_q;
    assign word_full = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = 32'd0;
            cnt_d   = 2'd0;
        end else if (byte_en) begin
            shift_d = word_next;
            // 2-bit counter wraps to 0 after the 4th byte, ready for the next word.
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : byte_packer
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Loads word_count big-endian 32-bit instructions from a byte
//               stream into an instruction RAM starting at BASE_ADDR.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start, word_count - load request and its length in words
//               in_valid, in_data - byte stream in
//               in_ready          - loader accepts a byte (LOAD only)
//               wr_en, wr_addr,
//               wr_data           - one-cycle RAM write strobe, address, data
//               busy, done, error - status: active, completion pulse,
//                                   sticky rejected-start flag
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state_q,    state_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q,    wr_en_d;
    logic [31:0] wr_addr_q,  wr_addr_d;
    logic [31:0] wr_data_q,  wr_data_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        error_q,    error_d;
    logic [15:0] index_q,    index_d;
    logic [15:0] count_q,    count_d;

    logic        w_byte_en;
    logic        w_reject;
    logic        w_pk_clear;
    logic [31:0] w_pk_word;
    logic        w_pk_full;

    // in_ready_q is high exactly while in LOAD, so it doubles as the accept qualifier.
    assign w_byte_en = in_valid && in_ready_q;
    // 32-bit compare keeps this correct for any DEPTH_WORDS value.
    assign w_reject  = (word_count == 16'd0) ||
                       (32'(word_count) > 32'(DEPTH_WORDS));

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_pk_clear),
        .byte_en   (w_byte_en),
        .byte_in   (in_data),
        .word_next (w_pk_word),
        .word_full (w_pk_full)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        index_d    = index_q;
        count_d    = count_q;
        w_pk_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (w_reject) begin
                        error_d = 1'b1;
                    end else begin
                        error_d    = 1'b0;
                        count_d    = word_count;
                        index_d    = 16'd0;
                        w_pk_clear = 1'b1;
                        state_d    = ST_LOAD;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // start is deliberately not looked at here: a busy loader ignores it.
                if (w_pk_full) begin
                    state_d    = ST_WRITE;
                    in_ready_d = 1'b0;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = word_addr(BASE_ADDR, index_q);
                    wr_data_d  = w_pk_word;
                end
            end
            ST_WRITE: begin
                index_d = index_q + 16'd1;
                if ((index_q + 16'd1) == count_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = ST_LOAD;
                    in_ready_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            index_q    <= 16'd0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            index_q    <= index_d;
            count_q    <= count_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule : instruction_loader
`default_nettype wire

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, the number of 32-bit words in the target instruction RAM.
REQ-002 SHALL have parameter BASE_ADDR, default 32'd0, the byte address of word 0; it is a multiple of 4.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port word_count  input  16  number of words to load, sampled on an accepted start.
REQ-007 SHALL have port in_valid  input  1  byte stream valid.
REQ-008 SHALL have port in_data  input  8  byte stream data.
REQ-009 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-010 SHALL have port wr_en  output  1  write strobe to the instruction RAM.
REQ-011 SHALL have port wr_addr  output  32  byte address of the write, always a multiple of 4.
REQ-012 SHALL have port wr_data  output  32  assembled MIPS instruction word.
REQ-013 SHALL have port busy  output  1  high from the accepted start until return to IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-015 SHALL have port error  output  1  sticky flag for a rejected start, cleared by the next accepted start.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WRITE and DONE.
REQ-017 SHALL leave IDLE only on start=1; an accepted start clears error, latches word_count and zeroes the word index and byte counter.
REQ-018 SHALL reject start with word_count=0 or word_count>DEPTH_WORDS: set error=1, stay in IDLE, never assert wr_en or done.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL drive in_ready=1 only in LOAD; a byte is accepted when in_valid && in_ready.
REQ-021 SHALL pack bytes big-endian: the 1st accepted byte goes to bits 31:24, the 4th to bits 7:0.
REQ-022 SHALL hold state on in_valid=0 bubbles; bubbles of any length cause no data loss.
REQ-023 SHALL enter WRITE in the cycle after the 4th byte of a word is accepted.
REQ-024 SHALL, in WRITE, assert wr_en for exactly one cycle with wr_addr=BASE_ADDR+4*index and wr_data=the packed word; in_ready=0 during WRITE.
REQ-025 SHALL, after WRITE, increment index and go to DONE if index+1==word_count, otherwise return to LOAD with byte counter 0.
REQ-026 SHALL, in DONE, pulse done=1 for one cycle, then go to IDLE; busy=1 in LOAD, WRITE and DONE.
REQ-027 SHALL have a latency of 1 cycle from acceptance of the 4th byte to wr_en, and 1 cycle from the last wr_en to done; peak throughput is one word per 5 cycles.
REQ-028 SHALL hold wr_addr and wr_data at their last written values when wr_en=0.
REQ-029 SHALL compute index arithmetic at 16 bits and address arithmetic at 32 bits; REQ-018 guarantees no address wrap.

Reset
REQ-030 SHALL, on rst=1 at any time, asynchronously force state=IDLE and in_ready, wr_en, busy, done and error to 0, and wr_addr, wr_data, index and byte counter to 0.
REQ-031 SHALL discard a partially packed word on reset mid-load; nothing is written for it.

Structure
REQ-032 SHALL take the FSM state encoding, BYTES_PER_WORD=4 and WORD_BYTES_SHIFT=2 from the shared project package.
REQ-033 SHALL place byte packing in one sub-module, byte_packer: a 32-bit shift register with a 2-bit byte counter and a word_full output.

Verification
REQ-034 SHALL verify a 2-word load with bytes 20 00 00 03 20 21 00 04 -> wr_en at addr 0 with data 0x20000003, then at addr 4 with data 0x20210004, and done exactly 1 cycle after the second write.
REQ-035 SHALL verify random in_valid gaps on the same stream -> identical writes, and no byte accepted while in_ready=0.
REQ-036 SHALL verify start with word_count=0, and separately with word_count=65 at DEPTH_WORDS=64 -> error=1, busy=0, no wr_en, no done.
REQ-037 SHALL verify rst asserted after 2 bytes of word 0, then a new 1-word load of 00 00 00 05 -> all outputs 0 during reset, then a single write at addr 0 with data 0x00000005.
REQ-038 SHALL verify a start pulse during LOAD with word_count=1 -> ignored; the original word_count completes unchanged.
REQ-039 SHALL verify a BASE_ADDR=32'h100 load of 3 words -> writes at 0x100, 0x104 and 0x108.
